// File: rtl/top_sobel_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : top_sobel_edge_detect
// Purpose  : Image-processing top built from two true dual-port BRAMs and a
//            controller. BRAM0 holds the source image, BRAM1 the result. The
//            host owns port 0 of both RAMs. The controller owns port 1 and
//            either copies pixels (i_run=0) or writes the saturated 3x3 Sobel
//            gradient magnitude of each pixel (i_run=1).
// Ports    : clk, rst_n              clock / async active-low reset
//            i_en, i_num_cnt, i_run  start pulse, pixel count, mode
//            o_idle/o_read/o_write   state indicators
//            o_done                  one-cycle completion pulse
//            b0_*0, b1_*0            host port 0 of BRAM0 / BRAM1
// Revision : 1.0 - initial release
// ============================================================================
module top_sobel_edge_detect #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_SIZE     = 65536,
  parameter int IMAGE_WIDTH  = 100,
  parameter int IMAGE_HEIGHT = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_num_cnt,
  input  logic                  i_run,
  output logic                  o_idle,
  output logic                  o_read,
  output logic                  o_write,
  output logic                  o_done,
  input  logic                  b0_ce0,
  input  logic                  b0_we0,
  input  logic [DATA_WIDTH-1:0] b0_d0,
  input  logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic [DATA_WIDTH-1:0] b0_q0,
  input  logic                  b1_ce0,
  input  logic                  b1_we0,
  input  logic [DATA_WIDTH-1:0] b1_d0,
  input  logic [ADDR_WIDTH-1:0] b1_addr0,
  output logic [DATA_WIDTH-1:0] b1_q0
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // 12 bits holds +/-4*255 for each gradient component.
  localparam int                      c_ACC_W = 12;
  localparam logic [ADDR_WIDTH-1:0]   c_W     = ADDR_WIDTH'(IMAGE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]   c_H     = ADDR_WIDTH'(IMAGE_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0]   c_ONE   = ADDR_WIDTH'(1);
  localparam logic [c_ACC_W-1:0]      c_SAT   = c_ACC_W'((1 << DATA_WIDTH) - 1);

  logic [DATA_WIDTH-1:0] mem0 [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem1 [MEM_SIZE];

  logic [1:0]                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pix_q, pix_d, row_q, row_d, col_q, col_d, num_q, num_d;
  logic                      run_q, run_d;
  logic [3:0]                rd_cnt_q, rd_cnt_d;
  logic signed [c_ACC_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [DATA_WIDTH-1:0]     cp_q, cp_d;
  logic [DATA_WIDTH-1:0]     b0_q0_q, b0_q1_q, b1_q0_q;

  logic                      w_b0_ce1, w_b1_we1;
  logic [ADDR_WIDTH-1:0]     w_rd_addr;
  logic [3:0]                w_n_rd;
  logic                      w_border, w_col_wrap, w_nxt_border;
  logic [ADDR_WIDTH-1:0]     w_nxt_col, w_nxt_row;
  logic signed [c_ACC_W-1:0] w_px, w_px2, w_gx_term, w_gy_term;
  logic [c_ACC_W-1:0]        w_abs_x, w_abs_y, w_mag;
  logic [DATA_WIDTH-1:0]     w_sat, w_result;

  assign o_idle  = (state_q == c_IDLE);
  assign o_read  = (state_q == c_READ);
  assign o_write = (state_q == c_WRITE);
  assign o_done  = (state_q == c_DONE);
  assign b0_q0   = b0_q0_q;
  assign b1_q0   = b1_q0_q;

  // Raster position tracking: col wraps at the image width, then row steps.
  assign w_border     = (row_q == '0) || (col_q == '0) ||
                        (row_q == c_H - c_ONE) || (col_q == c_W - c_ONE);
  assign w_col_wrap   = (col_q == c_W - c_ONE);
  assign w_nxt_col    = w_col_wrap ? '0 : col_q + c_ONE;
  assign w_nxt_row    = w_col_wrap ? row_q + c_ONE : row_q;
  assign w_nxt_border = (w_nxt_row == '0) || (w_nxt_col == '0) ||
                        (w_nxt_row == c_H - c_ONE) || (w_nxt_col == c_W - c_ONE);

  assign w_n_rd = run_q ? 4'd9 : 4'd1;

  // Window read order is row-major from the top-left neighbour.
  always_comb begin
    w_rd_addr = pix_q;
    if (run_q) begin
      case (rd_cnt_q)
        4'd0:    w_rd_addr = pix_q - c_W - c_ONE;
        4'd1:    w_rd_addr = pix_q - c_W;
        4'd2:    w_rd_addr = pix_q - c_W + c_ONE;
        4'd3:    w_rd_addr = pix_q - c_ONE;
        4'd5:    w_rd_addr = pix_q + c_ONE;
        4'd6:    w_rd_addr = pix_q + c_W - c_ONE;
        4'd7:    w_rd_addr = pix_q + c_W;
        4'd8:    w_rd_addr = pix_q + c_W + c_ONE;
        default: w_rd_addr = pix_q;
      endcase
    end
  end

  // Data for read k lands one cycle later, so rd_cnt_q = k+1 selects its weight.
  assign w_px  = signed'(c_ACC_W'(b0_q1_q));
  assign w_px2 = w_px + w_px;

  always_comb begin
    w_gx_term = '0;
    w_gy_term = '0;
    case (rd_cnt_q)
      4'd1:    begin w_gx_term = -w_px;  w_gy_term = -w_px; end
      4'd2:    w_gy_term = -w_px2;
      4'd3:    begin w_gx_term = w_px;   w_gy_term = -w_px; end
      4'd4:    w_gx_term = -w_px2;
      4'd6:    w_gx_term = w_px2;
      4'd7:    begin w_gx_term = -w_px;  w_gy_term = w_px;  end
      4'd8:    w_gy_term = w_px2;
      4'd9:    begin w_gx_term = w_px;   w_gy_term = w_px;  end
      default: ;
    endcase
  end

  assign w_abs_x  = gx_q[c_ACC_W-1] ? c_ACC_W'(-gx_q) : c_ACC_W'(gx_q);
  assign w_abs_y  = gy_q[c_ACC_W-1] ? c_ACC_W'(-gy_q) : c_ACC_W'(gy_q);
  assign w_mag    = w_abs_x + w_abs_y;
  assign w_sat    = (w_mag > c_SAT) ? '1 : w_mag[DATA_WIDTH-1:0];
  assign w_result = !run_q ? cp_q : (w_border ? '0 : w_sat);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    row_d    = row_q;
    col_d    = col_q;
    num_d    = num_q;
    run_d    = run_q;
    rd_cnt_d = rd_cnt_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    cp_d     = cp_q;
    w_b0_ce1 = 1'b0;
    w_b1_we1 = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (i_en) begin
          num_d    = i_num_cnt;
          run_d    = i_run;
          pix_d    = '0;
          row_d    = '0;
          col_d    = '0;
          rd_cnt_d = '0;
          gx_d     = '0;
          gy_d     = '0;
          // Pixel 0 sits on row 0, so Sobel mode starts straight in WRITE.
          if (i_num_cnt == '0) state_d = c_DONE;
          else if (i_run)      state_d = c_WRITE;
          else                 state_d = c_READ;
        end
      end
      c_READ: begin
        w_b0_ce1 = (rd_cnt_q < w_n_rd);
        if (rd_cnt_q != '0) begin
          if (run_q) begin
            gx_d = gx_q + w_gx_term;
            gy_d = gy_q + w_gy_term;
          end else begin
            cp_d = b0_q1_q;
          end
        end
        if (rd_cnt_q == w_n_rd) state_d = c_WRITE;
        else                    rd_cnt_d = rd_cnt_q + 4'd1;
      end
      c_WRITE: begin
        w_b1_we1 = 1'b1;
        if (pix_q == num_q - c_ONE) begin
          state_d = c_DONE;
        end else begin
          pix_d    = pix_q + c_ONE;
          row_d    = w_nxt_row;
          col_d    = w_nxt_col;
          rd_cnt_d = '0;
          gx_d     = '0;
          gy_d     = '0;
          state_d  = (run_q && w_nxt_border) ? c_WRITE : c_READ;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_IDLE;
      pix_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      num_q    <= '0;
      run_q    <= 1'b0;
      rd_cnt_q <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      cp_q     <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      row_q    <= row_d;
      col_q    <= col_d;
      num_q    <= num_d;
      run_q    <= run_d;
      rd_cnt_q <= rd_cnt_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      cp_q     <= cp_d;
    end
  end

  // RAM arrays: contents survive reset. Controller only reads BRAM0 and only
  // writes BRAM1 on port 1.
  always_ff @(posedge clk) begin
    if (b0_ce0 && b0_we0) mem0[b0_addr0] <= b0_d0;
  end

  always_ff @(posedge clk) begin
    if (b1_ce0 && b1_we0) mem1[b1_addr0] <= b1_d0;
    if (w_b1_we1)         mem1[pix_q]    <= w_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q0_q <= '0;
      b0_q1_q <= '0;
      b1_q0_q <= '0;
    end else begin
      if (b0_ce0 && !b0_we0) b0_q0_q <= mem0[b0_addr0];
      if (w_b0_ce1)          b0_q1_q <= mem0[w_rd_addr];
      if (b1_ce0 && !b1_we0) b1_q0_q <= mem1[b1_addr0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_top_sobel_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_sobel_edge_detect
// Purpose  : Self-checking bench for top_sobel_edge_detect. Random and
//            structured images are loaded through port 0, copy/Sobel runs are
//            started, and BRAM1 plus state-indicator activity are compared
//            against an arithmetic reference of the image operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_sobel_edge_detect;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int W     = 100;
  localparam int H     = 100;
  localparam int IMG_N = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_en, i_run;
  logic [AW-1:0] i_num_cnt;
  logic          o_idle, o_read, o_write, o_done;
  logic          b0_ce0, b0_we0, b1_ce0, b1_we0;
  logic [DW-1:0] b0_d0, b1_d0, b0_q0, b1_q0;
  logic [AW-1:0] b0_addr0, b1_addr0;

  always #5 clk = ~clk;

  top_sobel_edge_detect #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(65536),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_num_cnt(i_num_cnt), .i_run(i_run),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_d0(b0_d0), .b0_addr0(b0_addr0), .b0_q0(b0_q0),
    .b1_ce0(b1_ce0), .b1_we0(b1_we0), .b1_d0(b1_d0), .b1_addr0(b1_addr0), .b1_q0(b1_q0)
  );

  int n_cmp = 0;
  int n_err = 0;
  int img    [IMG_N];
  int b1_exp [IMG_N];
  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_border(input int idx);
    int r = idx / W;
    int c = idx % W;
    return (r == 0) || (c == 0) || (r == H - 1) || (c == W - 1);
  endfunction

  // Reference result for one pixel straight from the operator definition.
  function automatic int ref_pix(input int idx, input bit run);
    int r, c, gx, gy, p, s;
    if (!run) return img[idx];
    if (is_border(idx)) return 0;
    r = idx / W; c = idx % W; gx = 0; gy = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        p  = img[(r + dr) * W + (c + dc)];
        gx += kx[dr + 1][dc + 1] * p;
        gy += ky[dr + 1][dc + 1] * p;
      end
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int exp_reads(input int num, input bit run);
    int n = 0;
    if (!run) return 2 * num;
    for (int i = 0; i < num; i++) if (!is_border(i)) n += 10;
    return n;
  endfunction

  task automatic load_b0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b0_ce0 = 1'b1; b0_we0 = 1'b1; b0_addr0 = AW'(i); b0_d0 = DW'(img[i]);
    end
    @(negedge clk);
    b0_ce0 = 1'b0; b0_we0 = 1'b0;
  endtask

  task automatic fill_b1(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b1_ce0 = 1'b1; b1_we0 = 1'b1; b1_addr0 = AW'(i); b1_d0 = DW'(val);
      b1_exp[i] = val;
    end
    @(negedge clk);
    b1_ce0 = 1'b0; b1_we0 = 1'b0;
  endtask

  task automatic read_b1(input int addr, output int q);
    @(negedge clk);
    b1_ce0 = 1'b1; b1_we0 = 1'b0; b1_addr0 = AW'(addr);
    @(negedge clk);
    b1_ce0 = 1'b0;
    q = int'(b1_q0);
  endtask

  task automatic verify_b1(input string tag, input int n);
    int q;
    for (int i = 0; i < n; i++) begin
      read_b1(i, q);
      check_val($sformatf("%s b1[%0d]", tag, i), q, b1_exp[i]);
    end
  endtask

  // Starts a run, counts indicator cycles until o_done, then checks activity.
  // poke >= 0 re-pulses i_en with different settings at that cycle.
  task automatic do_run(input string tag, input bit run, input int num, input int poke);
    int rd, wr, lat, cyc;
    bit seen;
    rd = 0; wr = 0; lat = -1; seen = 1'b0;
    @(negedge clk);
    i_en = 1'b1; i_run = run; i_num_cnt = AW'(num);
    @(negedge clk);
    i_en = 1'b0;
    for (cyc = 0; cyc < 30000; cyc++) begin
      if (cyc == poke) begin
        i_en = 1'b1; i_run = !run; i_num_cnt = AW'(3);
      end else begin
        i_en = 1'b0;
      end
      if (o_read)  rd++;
      if (o_write) wr++;
      if (o_done) begin seen = 1'b1; lat = cyc; break; end
      @(negedge clk);
    end
    i_en = 1'b0;
    check_val({tag, " done seen"}, int'(seen), 1);
    check_val({tag, " read cycles"}, rd, exp_reads(num, run));
    check_val({tag, " write cycles"}, wr, num);
    check_val({tag, " done latency"}, lat, exp_reads(num, run) + num);
    @(negedge clk);
    check_val({tag, " done width"}, int'(o_done), 0);
    check_val({tag, " idle after"}, int'(o_idle), 1);
    for (int i = 0; i < num; i++) b1_exp[i] = ref_pix(i, run);
  endtask

  initial begin
    int q, dones;
    rst_n = 1'b0; i_en = 1'b0; i_run = 1'b0; i_num_cnt = '0;
    b0_ce0 = 1'b0; b0_we0 = 1'b0; b0_d0 = '0; b0_addr0 = '0;
    b1_ce0 = 1'b0; b1_we0 = 1'b0; b1_d0 = '0; b1_addr0 = '0;
    repeat (3) @(negedge clk);
    check_val("rst o_idle", int'(o_idle), 1);
    check_val("rst o_read", int'(o_read), 0);
    check_val("rst o_write", int'(o_write), 0);
    check_val("rst o_done", int'(o_done), 0);
    check_val("rst b0_q0", int'(b0_q0), 0);
    check_val("rst b1_q0", int'(b1_q0), 0);
    rst_n = 1'b1;

    // Random image, copy mode, partial count.
    for (int i = 0; i < IMG_N; i++) img[i] = int'($urandom_range(0, 255));
    load_b0(1400);
    @(negedge clk); b0_ce0 = 1'b1; b0_we0 = 1'b0; b0_addr0 = AW'(777);
    @(negedge clk); b0_ce0 = 1'b0;
    check_val("b0 readback", int'(b0_q0), img[777]);
    fill_b1(1400, 8'hA5);
    do_run("copy", 1'b0, 1000, -1);
    verify_b1("copy", 1100);

    // Same random image through Sobel, 12 rows.
    do_run("sobel", 1'b1, 1200, -1);
    verify_b1("sobel", 1300);

    // Flat image: every gradient is zero.
    for (int i = 0; i < 400; i++) img[i] = 77;
    load_b0(400);
    fill_b1(400, 8'hA5);
    do_run("flat", 1'b1, 300, -1);
    verify_b1("flat", 350);

    // Vertical step edge between columns 49 and 50.
    for (int i = 0; i < 400; i++) img[i] = ((i % W) < 50) ? 0 : 100;
    load_b0(400);
    fill_b1(400, 8'hA5);
    do_run("step", 1'b1, 300, -1);
    verify_b1("step", 350);
    read_b1(149, q); check_val("step r1c49", q, 255);
    read_b1(150, q); check_val("step r1c50", q, 255);
    read_b1(151, q); check_val("step r1c51", q, 0);
    read_b1(49,  q); check_val("step r0c49", q, 0);
    read_b1(100, q); check_val("step r1c0", q, 0);

    // Zero count: immediate done, nothing written.
    fill_b1(2, 8'h5A);
    do_run("zero", 1'b1, 0, -1);
    verify_b1("zero", 2);

    // Single-pixel copy.
    img[0] = int'($urandom_range(0, 255));
    load_b0(1);
    do_run("one", 1'b0, 1, -1);
    verify_b1("one", 2);

    // Start pulse while busy must be ignored.
    for (int i = 0; i < 30; i++) img[i] = int'($urandom_range(0, 255));
    load_b0(30);
    fill_b1(30, 8'hA5);
    do_run("busy_en", 1'b0, 20, 3);
    verify_b1("busy_en", 25);

    // Asynchronous reset in the middle of a copy.
    for (int i = 0; i < 60; i++) img[i] = int'($urandom_range(0, 255));
    load_b0(60);
    fill_b1(60, 8'hA5);
    @(negedge clk); i_en = 1'b1; i_run = 1'b0; i_num_cnt = AW'(50);
    @(negedge clk); i_en = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst o_idle", int'(o_idle), 1);
    check_val("midrst o_read", int'(o_read), 0);
    check_val("midrst o_write", int'(o_write), 0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    check_val("midrst no done", dones, 0);
    check_val("midrst idle", int'(o_idle), 1);
    read_b1(0, q);  check_val("midrst b1[0]", q, img[0]);
    read_b1(49, q); check_val("midrst b1[49]", q, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
